// File: rtl/fin_sched_pkg.sv
// -----------------------------------------------------------------------------
// fin_sched_pkg
// Shared definitions for the final-address-mux source scheduler.
//   SEL_W     : width of the 4-bit select driven into the 10-input address mux
//   fin_state_t : scheduler states (IDLE, ISSUE, DONE)
// -----------------------------------------------------------------------------
package fin_sched_pkg;

    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } fin_state_t;

endpackage

// File: rtl/fin_sel_next.sv
// -----------------------------------------------------------------------------
// fin_sel_next
// Combinational finder for the next enabled mux source. Only present when
// FIN_SCHED_SRC_MASK_EN is defined; without the mask the scheduler simply
// increments the select.
// Ports:
//   mask      in  NUM_SRC  enabled sources (1 = issue a request for it)
//   sel       in  SEL_W    current select
//   sel_next  out SEL_W    next enabled index above sel, else first enabled
//   sel_first out SEL_W    lowest enabled index
//   wrap      out 1        no enabled index above sel (node must advance)
//   any       out 1        at least one source enabled
// -----------------------------------------------------------------------------
`ifdef FIN_SCHED_SRC_MASK_EN
module fin_sel_next
    import fin_sched_pkg::*;
#(
    parameter int NUM_SRC = 10
) (
    input  logic [NUM_SRC-1:0] mask,
    input  logic [SEL_W-1:0]   sel,
    output logic [SEL_W-1:0]   sel_next,
    output logic [SEL_W-1:0]   sel_first,
    output logic               wrap,
    output logic               any
);

    logic [SEL_W-1:0] hit_idx;
    logic             hit;

    // Descending scan so the last assignment is the lowest qualifying index.
    always_comb begin
        hit_idx   = '0;
        hit       = 1'b0;
        sel_first = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (mask[i]) begin
                sel_first = SEL_W'(i);
                if (i > int'(sel)) begin
                    hit_idx = SEL_W'(i);
                    hit     = 1'b1;
                end
            end
        end
        any      = |mask;
        wrap     = ~hit;
        sel_next = hit ? hit_idx : sel_first;
    end

endmodule
`endif

// File: rtl/fin_addr_sched.sv
// -----------------------------------------------------------------------------
// fin_addr_sched
// Per-node address-source scheduler for the LBM streaming/collision memory
// path. Sweeps the final address mux select over NUM_SRC sources for each of
// NUM_NODES lattice nodes, issuing one req/gnt beat per source.
//
// Optional build macro: FIN_SCHED_SRC_MASK_EN adds src_mask, captured at start,
// so that disabled sources are skipped without idle cycles.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset_n   in   synchronous active-low reset
//   start     in   one-cycle pulse, begins a sweep when idle
//   abort     in   level; ends the sweep next cycle (wins over mem_gnt)
//   mem_gnt   in   memory accepts the current request
//   src_mask  in   [NUM_SRC] enabled sources (FIN_SCHED_SRC_MASK_EN only)
//   select    out  mux select, valid while mem_req=1
//   node_idx  out  current lattice node
//   mem_req   out  request valid, held until granted
//   busy      out  high from the cycle after start until back in IDLE
//   done      out  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module fin_addr_sched
    import fin_sched_pkg::*;
#(
    parameter int NUM_SRC   = 10,
    parameter int NUM_NODES = 64,
    parameter int NODE_W    = 6
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               mem_gnt,
`ifdef FIN_SCHED_SRC_MASK_EN
    input  logic [NUM_SRC-1:0] src_mask,
`endif
    output logic [SEL_W-1:0]   select,
    output logic [NODE_W-1:0]  node_idx,
    output logic               mem_req,
    output logic               busy,
    output logic               done
);

    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_SRC - 1);
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);

    fin_state_t        state, state_n;
    logic [SEL_W-1:0]  sel_n;
    logic [NODE_W-1:0] node_n;
    logic              req_n, busy_n, done_n;

    logic [SEL_W-1:0]  sel_adv;    // select for the next beat within this node
    logic [SEL_W-1:0]  sel_first;  // select for the first beat of a node
    logic              sel_wrap;   // current beat is the last of this node
    logic              src_any;    // sweep has at least one beat

`ifdef FIN_SCHED_SRC_MASK_EN
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] mask_use;

    // In IDLE the finder looks at the live mask so the first select is
    // already correct on the cycle after start.
    assign mask_use = (state == IDLE) ? src_mask : mask_q;

    fin_sel_next #(
        .NUM_SRC (NUM_SRC)
    ) u_sel_next (
        .mask      (mask_use),
        .sel       (select),
        .sel_next  (sel_adv),
        .sel_first (sel_first),
        .wrap      (sel_wrap),
        .any       (src_any)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            mask_q <= '0;
        end else if (state == IDLE && start && !abort) begin
            mask_q <= src_mask;
        end
    end
`else
    assign sel_adv   = select + SEL_W'(1);
    assign sel_first = '0;
    assign sel_wrap  = (select == LAST_SEL);
    assign src_any   = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            select   <= '0;
            node_idx <= '0;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            select   <= sel_n;
            node_idx <= node_n;
            mem_req  <= req_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = select;
        node_n  = node_idx;
        req_n   = mem_req;
        busy_n  = busy;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                sel_n  = '0;
                node_n = '0;
                req_n  = 1'b0;
                busy_n = 1'b0;
                if (start && !abort) begin
                    busy_n = 1'b1;
                    if (src_any) begin
                        state_n = ISSUE;
                        sel_n   = sel_first;
                        req_n   = 1'b1;
                    end else begin
                        // Empty sweep: DONE is entered with done low so the
                        // pulse lands one cycle later.
                        state_n = DONE;
                    end
                end
            end

            ISSUE: begin
                if (abort) begin
                    state_n = IDLE;
                    sel_n   = '0;
                    node_n  = '0;
                    req_n   = 1'b0;
                    busy_n  = 1'b0;
                end else if (mem_req && mem_gnt) begin
                    if (!sel_wrap) begin
                        sel_n = sel_adv;
                    end else if (node_idx != LAST_NODE) begin
                        sel_n  = sel_first;
                        node_n = node_idx + NODE_W'(1);
                    end else begin
                        state_n = DONE;
                        req_n   = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end

            DONE: begin
                if (abort || done) begin
                    state_n = IDLE;
                    sel_n   = '0;
                    node_n  = '0;
                    req_n   = 1'b0;
                    busy_n  = 1'b0;
                end else begin
                    done_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                sel_n   = '0;
                node_n  = '0;
                req_n   = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fin_addr_sched.sv
// -----------------------------------------------------------------------------
// tb_fin_addr_sched
// Directed bench for fin_addr_sched with NUM_SRC=10, NUM_NODES=2.
// -----------------------------------------------------------------------------
module tb_fin_addr_sched;

    localparam int NUM_SRC   = 10;
    localparam int NUM_NODES = 2;
    localparam int NODE_W    = 6;

    logic              Clk     = 1'b0;
    logic              Reset_n = 1'b0;
    logic              start   = 1'b0;
    logic              abort   = 1'b0;
    logic              mem_gnt = 1'b0;
`ifdef FIN_SCHED_SRC_MASK_EN
    logic [NUM_SRC-1:0] src_mask = '0;
`endif
    logic [3:0]        select;
    logic [NODE_W-1:0] node_idx;
    logic              mem_req;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    fin_addr_sched #(
        .NUM_SRC   (NUM_SRC),
        .NUM_NODES (NUM_NODES),
        .NODE_W    (NODE_W)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .abort    (abort),
        .mem_gnt  (mem_gnt),
`ifdef FIN_SCHED_SRC_MASK_EN
        .src_mask (src_mask),
`endif
        .select   (select),
        .node_idx (node_idx),
        .mem_req  (mem_req),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_sel"},  int'(select),   0);
        check_val({tag, "_node"}, int'(node_idx), 0);
        check_val({tag, "_req"},  int'(mem_req),  0);
        check_val({tag, "_busy"}, int'(busy),     0);
        check_val({tag, "_done"}, int'(done),     0);
    endtask

    // Leaves the bench sampling the cycle in which done is high.
    task automatic wait_done(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < limit && !seen; c++) begin
            if (done) seen = 1'b1;
            else step();
        end
        check_val(tag, int'(seen), 1);
    endtask

    initial begin
        int beats;
        int dones;

        // Reset state
        mem_gnt = 1'b1;
        step();
        step();
        check_idle("rst");
        Reset_n = 1'b1;
        step();
        check_idle("post_rst");

        // Full sweep with gnt tied high: 20 back-to-back beats
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            check_val("sweep_req",  int'(mem_req),  1);
            check_val("sweep_sel",  int'(select),   k % 10);
            check_val("sweep_node", int'(node_idx), k / 10);
            check_val("sweep_done", int'(done),     0);
            step();
        end
        check_val("sweep_end_done", int'(done),    1);
        check_val("sweep_end_busy", int'(busy),    1);
        check_val("sweep_end_req",  int'(mem_req), 0);
        step();
        check_idle("sweep_idle");

        // Grant stall at select 4
        pulse_start();
        repeat (4) step();
        check_val("stall_pre_sel", int'(select), 4);
        mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("stall_sel",  int'(select),   4);
            check_val("stall_node", int'(node_idx), 0);
            check_val("stall_req",  int'(mem_req),  1);
        end
        mem_gnt = 1'b1;
        step();
        check_val("stall_adv_sel", int'(select), 5);
        wait_done("stall_done", 40);
        step();
        check_val("stall_idle_busy", int'(busy), 0);

        // Abort together with a grant at node 1, select 7
        pulse_start();
        repeat (17) step();
        check_val("abort_pre_sel",  int'(select),   7);
        check_val("abort_pre_node", int'(node_idx), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort");
        dones = 0;
        repeat (30) begin
            if (done) dones++;
            step();
        end
        check_val("abort_no_done", dones, 0);

        // start while busy is ignored
        pulse_start();
        beats = 0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            start = (c == 5);
            if (mem_req && mem_gnt) beats++;
            if (done) dones++;
            step();
        end
        start = 1'b0;
        check_val("restart_beats", beats, 20);
        check_val("restart_dones", dones, 1);
        check_val("restart_busy",  int'(busy), 0);

        // Reset mid-sweep
        pulse_start();
        repeat (7) step();
        check_val("midrst_pre_sel", int'(select), 7);
        Reset_n = 1'b0;
        step();
        check_idle("midrst");
        Reset_n = 1'b1;
        step();
        check_idle("midrst_after");
        pulse_start();
        check_val("midrst_re_sel",  int'(select),   0);
        check_val("midrst_re_node", int'(node_idx), 0);
        check_val("midrst_re_req",  int'(mem_req),  1);
        repeat (3) step();
        check_val("midrst_re_sel3", int'(select), 3);
        wait_done("midrst_done", 40);
        step();

        // abort with start in IDLE stays idle
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_idle("abort_start");

`ifdef FIN_SCHED_SRC_MASK_EN
        // Masked sweep: selects 0, 1, 9 per node
        begin
            int exp_sel [6] = '{0, 1, 9, 0, 1, 9};
            src_mask = 10'b10_0000_0011;
            pulse_start();
            for (int k = 0; k < 6; k++) begin
                check_val("mask_req",  int'(mem_req),  1);
                check_val("mask_sel",  int'(select),   exp_sel[k]);
                check_val("mask_node", int'(node_idx), k / 3);
                step();
            end
            check_val("mask_done", int'(done), 1);
            step();
            check_idle("mask_idle");
        end

        // All-zero mask: done two cycles after start, never a request
        src_mask = '0;
        pulse_start();
        check_val("zmask_req1",  int'(mem_req), 0);
        check_val("zmask_busy1", int'(busy),    1);
        check_val("zmask_done1", int'(done),    0);
        step();
        check_val("zmask_req2",  int'(mem_req), 0);
        check_val("zmask_done2", int'(done),    1);
        step();
        check_idle("zmask_idle");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
